sync_fifo_prog: RTL and testbench
=================================

# sync_fifo_prog

Single-clock, parametrised FIFO that succeeds the async_fifo used in lab 4. It adds:
- selectable first-word-fall-through (FWFT) or registered read mode;
- an occupancy count output;
- runtime-programmable almost-full and almost-empty thresholds;
- sticky overflow/underflow error flags;
- a synchronous flush.

It sits between a single-clock producer and consumer, and the DPI C FIFO model remains the scoreboard reference.

## Interface
- DSIZE, 8, data width in bits
- ASIZE, 4, address width; depth DEPTH = 2**ASIZE
- FWFT, 1, 1 = head word visible on rdata while not empty; 0 = registered read with 1-cycle latency
- clk  input  1  single clock; all logic on posedge
- rst_n  input  1  reset, asynchronous assert, active-low
- wdata  input  DSIZE  write data
- winc  input  1  push request
- rinc  input  1  pop request
- flush  input  1  synchronous clear of pointers and count
- clr_err  input  1  synchronous clear of overflow/underflow
- af_thresh  input  ASIZE+1  almost_full threshold
- ae_thresh  input  ASIZE+1  almost_empty threshold
- rdata  output  DSIZE  read data
- rvalid  output  1  FWFT=0 only: rdata updated this cycle (always 0 when FWFT=1)
- wfull  output  1  count == DEPTH
- rempty  output  1  count == 0
- almost_full  output  1  count >= af_thresh
- almost_empty  output  1  count <= ae_thresh
- count  output  ASIZE+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: push attempted while full and not accepted
- underflow  output  1  sticky: pop attempted while empty

## Operation
- Pointers: wptr and rptr are ASIZE+1-bit binary. Memory index is ptr[ASIZE-1:0]; the MSB distinguishes wrap. count = wptr - rptr, modulo 2**(ASIZE+1).
- Pop accepted: pop_ok = rinc && !rempty.
- Push accepted: push_ok = winc && (!wfull || pop_ok). When full, a simultaneous pop frees the slot and both are accepted.
- Count update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- Empty with winc=1 and rinc=1: the push is accepted, the pop is rejected, and underflow is set.
- Full with winc=1 and rinc=0: the push is dropped and overflow is set. The memory is not written.
- Flags are combinational functions of the registered count.
- FWFT=1:
  - rdata = mem[rptr] while !rempty, else 0.
  - After a pop, the next word appears on rdata in the following cycle.
- FWFT=0:
  - On pop_ok, rdata <= mem[rptr] and rvalid=1 in the next cycle.
  - rdata holds its value otherwise.
- Flush:
  - wptr, rptr and count go to 0; memory contents are not cleared.
  - Flush has priority over push and pop in the same cycle; the push is dropped and no error is set.
- clr_err clears both error flags. An error event in the same cycle as clr_err wins, so the flag stays 1.
- Reset (async, rst_n=0), any time including mid-burst:
  - wptr=rptr=0, count=0, rempty=1, wfull=0;
  - overflow=underflow=0, rdata=0, rvalid=0;
  - almost_empty=1; almost_full=1 only if af_thresh==0.

## Timing
- All state updates occur on posedge clk. Outputs are valid one cycle after the causing edge.
- Write-to-read latency:
  - FWFT=1: a word pushed at edge N is on rdata after edge N, so it is poppable at edge N+1.
  - FWFT=0: add one cycle from the pop to rvalid.
- Full turnaround: full with push and pop in the same cycle keeps count=DEPTH and wfull=1.
- Threshold inputs are sampled combinationally. A threshold change takes effect in the same cycle.

## Structure
- fifo_pkg: shared with the async_fifo bench. It holds:
  - typedef fifo_err_t (overflow and underflow bits);
  - constant functions depth(ASIZE) and cnt_w(ASIZE).
- Sub-module fifo_mem: DEPTH x DSIZE dual-port RAM with a synchronous write port and an asynchronous read port. It is instantiated once.
- Top level: pointers, count, flags, error logic, and the FWFT/registered read mux, selected by a generate on FWFT.

## Test plan
All scenarios use DSIZE=8, ASIZE=4. Results are scoreboarded against the DPI model.
- Reset, then push AA, BB, CC, DD → count=4, rempty=0; in FWFT mode rdata=AA before any pop; pops return AA, BB, CC, DD, then rempty=1.
- Push 16 words 00..0F → wfull=1, count=16; a 17th push (winc only) is dropped and overflow=1; pops return 00..0F.
- Full, with push 55 and pop together → both accepted, count stays 16, and the final pop returns 55.
- Set af_thresh=12 and ae_thresh=3, then push 12 words → almost_full rises at count 12 and almost_empty falls at count 4; a pop returns almost_full to 0.
- Empty, with rinc=1 and winc=1 (data 77) → underflow=1, count=1, rdata=77; clr_err → underflow=0.
- FWFT=0, 8 words pushed, flush together with a push → count=0, rempty=1, no error; then push 99 and pop → rvalid=1 with rdata=99 one cycle later. Asserting rst_n=0 mid-burst returns all outputs to their reset values.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: error flag bundle and depth/count-width helpers.
package fifo_pkg;

   // Sticky error flags reported by the FIFO
   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;

   // Number of entries for a given address width
   function automatic int depth(input int asize);
      return 1 << asize;
   endfunction

   // Width of the occupancy count (must represent 0..DEPTH inclusive)
   function automatic int cnt_w(input int asize);
      return asize + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DSIZE storage: synchronous write port, asynchronous read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [ASIZE-1:0] waddr_i,
   input  logic [DSIZE-1:0] wdata_i,
   input  logic [ASIZE-1:0] raddr_i,
   output logic [DSIZE-1:0] rdata_o
);

   localparam int DEPTH = depth(ASIZE);

   logic [DSIZE-1:0] mem_q [DEPTH];

   // Write port; contents are deliberately not reset or flushed
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with FWFT/registered read, occupancy count,
// programmable almost thresholds, sticky errors and synchronous flush.
module sync_fifo_prog
   import fifo_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4,
   parameter int FWFT  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DSIZE-1:0] wdata,
   input  logic             winc,
   input  logic             rinc,
   input  logic             flush,
   input  logic             clr_err,
   input  logic [ASIZE:0]   af_thresh,
   input  logic [ASIZE:0]   ae_thresh,
   output logic [DSIZE-1:0] rdata,
   output logic             rvalid,
   output logic             wfull,
   output logic             rempty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam int            CW      = cnt_w(ASIZE);
   localparam logic [CW-1:0] DEPTH_C = CW'(depth(ASIZE));

   logic [CW-1:0]    wptr_q, wptr_d;
   logic [CW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    cnt;
   fifo_err_t        err_q, err_d;
   logic             pop_ok, push_ok, mem_we;
   logic             ovf_evt, unf_evt;
   logic [DSIZE-1:0] mem_rd;

   // Occupancy is the pointer distance; the extra MSB disambiguates full vs empty
   assign cnt          = wptr_q - rptr_q;
   assign count        = cnt;
   assign rempty       = (cnt == '0);
   assign wfull        = (cnt == DEPTH_C);
   assign almost_full  = (cnt >= af_thresh);
   assign almost_empty = (cnt <= ae_thresh);

   // A pop on a full FIFO frees the slot for a same-cycle push
   assign pop_ok  = rinc && !rempty;
   assign push_ok = winc && (!wfull || pop_ok);
   assign mem_we  = push_ok && !flush;

   // Flush suppresses both the transfer and any error it would have raised
   assign ovf_evt = winc && !push_ok && !flush;
   assign unf_evt = rinc && rempty && !flush;

   // Next pointers and error flags; a new error beats a same-cycle clear
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + CW'(1);
         if (pop_ok)  rptr_d = rptr_q + CW'(1);
      end
      err_d.overflow  = (err_q.overflow  && !clr_err) || ovf_evt;
      err_d.underflow = (err_q.underflow && !clr_err) || unf_evt;
   end

   // Pointer and error state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         err_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         err_q  <= err_d;
      end
   end

   assign overflow  = err_q.overflow;
   assign underflow = err_q.underflow;

   fifo_mem #(
      .DSIZE(DSIZE),
      .ASIZE(ASIZE)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (wptr_q[ASIZE-1:0]),
      .wdata_i (wdata),
      .raddr_i (rptr_q[ASIZE-1:0]),
      .rdata_o (mem_rd)
   );

   if (FWFT != 0) begin : g_fwft
      // Head word is visible directly; zero while empty
      assign rdata  = rempty ? '0 : mem_rd;
      assign rvalid = 1'b0;
   end else begin : g_reg
      logic [DSIZE-1:0] rdata_q, rdata_d;
      logic             rvalid_q, rvalid_d;
      logic             rd_en;

      assign rd_en    = pop_ok && !flush;
      assign rdata_d  = rd_en ? mem_rd : rdata_q;
      assign rvalid_d = rd_en;

      // Registered read: capture the head on an accepted pop, hold otherwise
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
         end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
   end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench: one FWFT instance (_a) and one registered-read instance (_b)
// driven by the same stimulus.
module tb_sync_fifo_prog;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] wdata;
   logic       winc, rinc, flush, clr_err;
   logic [4:0] af_thresh, ae_thresh;

   logic [7:0] rdata_a, rdata_b;
   logic       rvalid_a, rvalid_b, wfull_a, wfull_b, rempty_a, rempty_b;
   logic       af_a, af_b, ae_a, ae_b, ovf_a, ovf_b, unf_a, unf_b;
   logic [4:0] count_a, count_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sync_fifo_prog #(.DSIZE(8), .ASIZE(4), .FWFT(1)) u_a (
      .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
      .flush(flush), .clr_err(clr_err), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .rdata(rdata_a), .rvalid(rvalid_a), .wfull(wfull_a), .rempty(rempty_a),
      .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
      .overflow(ovf_a), .underflow(unf_a)
   );

   sync_fifo_prog #(.DSIZE(8), .ASIZE(4), .FWFT(0)) u_b (
      .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
      .flush(flush), .clr_err(clr_err), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .rdata(rdata_b), .rvalid(rvalid_b), .wfull(wfull_b), .rempty(rempty_b),
      .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
      .overflow(ovf_b), .underflow(unf_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock with the given push/pop request; strobes drop after the edge
   task automatic cyc(input logic w, input logic r, input logic [7:0] d);
      winc  = w;
      rinc  = r;
      wdata = d;
      @(posedge clk);
      #1;
      winc    = 1'b0;
      rinc    = 1'b0;
      flush   = 1'b0;
      clr_err = 1'b0;
   endtask

   task automatic check_reset();
      check("rst_count_a", count_a, 0);
      check("rst_count_b", count_b, 0);
      check("rst_rempty",  rempty_a, 1);
      check("rst_wfull",   wfull_a, 0);
      check("rst_ovf",     ovf_a, 0);
      check("rst_unf_a",   unf_a, 0);
      check("rst_unf_b",   unf_b, 0);
      check("rst_rdata_a", rdata_a, 0);
      check("rst_rdata_b", rdata_b, 0);
      check("rst_rvalid_b", rvalid_b, 0);
      check("rst_ae",      ae_a, 1);
      check("rst_af",      af_a, 0);
      af_thresh = 5'd0;
      #1;
      check("rst_af_thr0", af_a, 1);
      af_thresh = 5'd16;
      #1;
   endtask

   initial begin
      logic [7:0] exp_d;
      rst_n = 1'b0; wdata = '0; winc = 0; rinc = 0; flush = 0; clr_err = 0;
      af_thresh = 5'd16; ae_thresh = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check_reset();
      rst_n = 1'b1;

      // Basic push / pop ordering
      cyc(1, 0, 8'hAA); cyc(1, 0, 8'hBB); cyc(1, 0, 8'hCC); cyc(1, 0, 8'hDD);
      check("basic_count", count_a, 4);
      check("basic_rempty", rempty_a, 0);
      check("basic_head_a", rdata_a, 8'hAA);
      check("basic_rvalid_b_idle", rvalid_b, 0);
      cyc(0, 1, 8'h00);
      check("basic_pop1_a", rdata_a, 8'hBB);
      check("basic_pop1_b", rdata_b, 8'hAA);
      check("basic_pop1_rvalid_b", rvalid_b, 1);
      cyc(0, 1, 8'h00);
      check("basic_pop2_a", rdata_a, 8'hCC);
      cyc(0, 1, 8'h00);
      check("basic_pop3_a", rdata_a, 8'hDD);
      cyc(0, 1, 8'h00);
      check("basic_pop4_b", rdata_b, 8'hDD);
      check("basic_empty", rempty_a, 1);
      check("basic_empty_rdata_a", rdata_a, 0);

      // Fill to full, rejected 17th push, drain in order
      for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i));
      check("full_wfull", wfull_a, 1);
      check("full_count", count_a, 16);
      check("full_af", af_a, 1);
      cyc(1, 0, 8'hEE);
      check("full_ovf_a", ovf_a, 1);
      check("full_ovf_b", ovf_b, 1);
      check("full_count_after_drop", count_a, 16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("full_drain_%0d", i), rdata_a, 32'(i));
         cyc(0, 1, 8'h00);
      end
      check("full_drained", rempty_a, 1);
      clr_err = 1'b1;
      cyc(0, 0, 8'h00);
      check("clr_ovf", ovf_a, 0);

      // Full turnaround: simultaneous push and pop
      for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h10 + i));
      cyc(1, 1, 8'h55);
      check("turn_count", count_a, 16);
      check("turn_wfull", wfull_a, 1);
      check("turn_no_ovf", ovf_a, 0);
      check("turn_rdata_b", rdata_b, 8'h10);
      for (int i = 0; i < 16; i++) begin
         exp_d = (i < 15) ? 8'(8'h11 + i) : 8'h55;
         check($sformatf("turn_drain_%0d", i), rdata_a, 32'(exp_d));
         cyc(0, 1, 8'h00);
      end
      check("turn_last_b", rdata_b, 8'h55);

      // Programmable thresholds
      af_thresh = 5'd12; ae_thresh = 5'd3;
      #1;
      check("thr_ae_at0", ae_a, 1);
      check("thr_af_at0", af_a, 0);
      for (int k = 1; k <= 12; k++) begin
         cyc(1, 0, 8'(8'h40 + k));
         check($sformatf("thr_af_%0d", k), af_a, (k >= 12) ? 1 : 0);
         check($sformatf("thr_ae_%0d", k), ae_a, (k <= 3) ? 1 : 0);
      end
      cyc(0, 1, 8'h00);
      check("thr_pop_count", count_a, 11);
      check("thr_pop_af", af_a, 0);
      af_thresh = 5'd11;
      #1;
      check("thr_live_change", af_b, 1);
      af_thresh = 5'd16; ae_thresh = 5'd0;
      flush = 1'b1;
      cyc(0, 0, 8'h00);
      check("thr_flush_empty", rempty_a, 1);

      // Push+pop on empty: push wins, underflow raised
      cyc(1, 1, 8'h77);
      check("unf_flag_a", unf_a, 1);
      check("unf_flag_b", unf_b, 1);
      check("unf_count", count_a, 1);
      check("unf_rdata_a", rdata_a, 8'h77);
      check("unf_rvalid_b", rvalid_b, 0);
      clr_err = 1'b1;
      cyc(0, 0, 8'h00);
      check("unf_clr", unf_a, 0);
      cyc(0, 1, 8'h00);
      check("unf_pop_b", rdata_b, 8'h77);
      clr_err = 1'b1;
      cyc(0, 1, 8'h00);
      check("unf_err_beats_clr", unf_a, 1);
      clr_err = 1'b1;
      cyc(0, 0, 8'h00);
      check("unf_clr2", unf_a, 0);

      // Flush with concurrent push, then registered read latency
      for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'h30 + i));
      check("fl_pre_count", count_b, 8);
      flush = 1'b1;
      cyc(1, 0, 8'hEE);
      check("fl_count", count_b, 0);
      check("fl_rempty", rempty_b, 1);
      check("fl_no_ovf", ovf_b, 0);
      check("fl_no_unf", unf_b, 0);
      cyc(1, 0, 8'h99);
      check("fl_push_count", count_b, 1);
      check("fl_rvalid_before", rvalid_b, 0);
      cyc(0, 1, 8'h00);
      check("fl_rvalid", rvalid_b, 1);
      check("fl_rdata_b", rdata_b, 8'h99);
      cyc(0, 0, 8'h00);
      check("fl_rvalid_drop", rvalid_b, 0);
      check("fl_rdata_hold", rdata_b, 8'h99);

      // Asynchronous reset in the middle of a burst
      cyc(0, 1, 8'h00);
      check("mid_unf_set", unf_b, 1);
      cyc(1, 0, 8'h01); cyc(1, 0, 8'h02);
      winc = 1'b1; wdata = 8'h03;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      winc = 1'b0;
      check_reset();
      #3;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_count", count_a, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
